arrhythmia_infer_ctrl: RTL and testbench
========================================

Name: arrhythmia_infer_ctrl

Overview:
Sequencer that wraps the top_arrhythmia VAE/classifier datapath.
- Accepts one 10-feature Q4.11 sign-magnitude sample plus its true label over a valid/ready handshake.
- Pulses the datapath reset, holds the features stable, and waits for done_flag_out, with a timeout.
- Captures y1/y2, computes the prediction (y1 > y2, sign-magnitude) and presents the result over a valid/ready handshake.
- Keeps running total/correct/timeout counters, replacing the bench-side accuracy bookkeeping with hardware.

Parameters:
BITSIZE, 16, word width; Q4.11 sign-magnitude (bit15 sign, 14:11 integer, 10:0 fraction)
N_FEAT, 10, features per sample
CLR_CYCLES, 2, cycles dp_reset is held high per sample (>=1)
TIMEOUT, 255, max RUN cycles before abort (>=2)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  sample offered
in_ready  out  1  controller can accept a sample
in_x  in  BITSIZE*N_FEAT  features, feature 0 in MSBs
in_label  in  1  true class (1 = y1 expected greater)
dp_reset  out  1  active-high reset to the datapath
dp_x  out  BITSIZE*N_FEAT  features to the datapath
dp_done  in  1  datapath done_flag_out
dp_y1  in  BITSIZE  datapath output y1
dp_y2  in  BITSIZE  datapath output y2
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_pred  out  1  1 when y1 > y2
out_match  out  1  out_pred == label and not timeout
out_timeout  out  1  sample aborted by timeout
out_y1  out  BITSIZE  captured y1
out_y2  out  BITSIZE  captured y2
stat_clear  in  1  synchronous clear of statistics
stat_total  out  CNT_W  results delivered
stat_correct  out  CNT_W  matches delivered
stat_timeout  out  CNT_W  timeouts delivered
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, CLEAR, RUN, RESULT.
- Reset (reset == 0, asynchronous):
  - state IDLE, dp_reset 1, in_ready 1.
  - All other outputs, latched x/label, and the RUN and CLEAR counters are 0.
  - Reset mid-operation aborts the sample with no result.
- IDLE:
  - in_ready = 1, dp_reset = 1.
  - On in_valid & in_ready: latch in_x and in_label, go to CLEAR.
- CLEAR:
  - dp_reset = 1 and dp_x = latched x for exactly CLR_CYCLES cycles, then go to RUN.
  - dp_done is ignored, because a stale flag from the previous sample is possible.
- RUN:
  - dp_reset = 0; dp_x stays stable; the RUN counter starts at 0 and increments each cycle.
  - dp_done = 1: capture dp_y1/dp_y2, compute out_pred, out_timeout = 0, go to RESULT.
  - Counter == TIMEOUT-1 with dp_done = 0: out_y1 = out_y2 = 0, out_pred = 0, out_timeout = 1, go to RESULT.
  - dp_done on the timeout cycle takes priority: normal capture.
- RESULT:
  - out_valid = 1; all out_* held stable; dp_reset = 0; in_ready = 0.
  - On out_valid & out_ready: update statistics, go to IDLE. out_valid drops the next cycle.
- Latency: accept at edge 0, first RUN cycle at edge CLR_CYCLES+1. If dp_done is seen in RUN cycle k (k from 0), out_valid rises at edge CLR_CYCLES+k+2.
- Back-to-back: a new sample is accepted no earlier than one cycle after the result handshake (via IDLE).
- Comparator (y1 > y2, sign-magnitude):
  - Signs differ: the non-negative operand is greater.
  - Both positive: magnitude greater.
  - Both negative: magnitude smaller.
  - +0 and -0 are equal, so 0x8000 vs 0x0000 gives pred 0. Equal values give 0.
- Statistics:
  - On the handshake: stat_total += 1; stat_correct += out_match; stat_timeout += out_timeout.
  - Each counter saturates at 2^CNT_W-1.
  - stat_clear zeroes all three next cycle and wins over a coincident handshake increment.

Decomposition:
- Package arrhythmia_pkg:
  - state enum.
  - Q4.11 constants (SIGN_BIT = 15, ONE = 16'h0800).
  - Sign-magnitude greater-than function, shared with benches for the golden model.
- One sub-module: arrhythmia_sm_gt, a combinational BITSIZE-wide sign-magnitude comparator instanced in the capture path.
- Everything else stays in arrhythmia_infer_ctrl.

Test Plan:
1. CLR_CYCLES = 2; sample, label 1; stub raises dp_done at RUN cycle 3 with y1 = 0x0800, y2 = 0x0400 -> dp_reset high exactly 2 cycles; out_valid at edge 7; pred 1, match 1; after handshake total = 1, correct = 1.
2. y1 = 0x8800 (-1.0), y2 = 0x0400, label 1 -> pred 0, match 0. Separately, y1 = 0x8000, y2 = 0x0000 -> pred 0; y1 = 0x8400, y2 = 0x8800 -> pred 1.
3. TIMEOUT = 8, dp_done never asserted -> out_timeout 1 after 8 RUN cycles; out_y1/out_y2 = 0; total +1, timeout +1, correct unchanged. dp_done on RUN cycle 7 -> normal capture, no timeout.
4. out_ready held low 5 cycles -> out_valid and out_* stable, in_ready 0 with in_valid high, counters unchanged until the handshake; dp_done asserted during CLEAR is ignored.
5. reset pulled low during RUN -> immediately IDLE, dp_reset 1, out_valid 0, counters 0; the next sample completes normally.
6. stat_clear on the handshake cycle -> all counters 0. CNT_W = 2 with 5 correct results -> stat_correct saturates at 3.

Source files
------------

// File: rtl/arrhythmia_infer_ctrl_pkg.sv
// arrhythmia_pkg: shared states, Q4.11 constants and sign-magnitude compare
package arrhythmia_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESULT} state_t;
   localparam int SIGN_BIT = 15;
   localparam logic [15:0] ONE = 16'h0800;
   // +0 and -0 compare equal, so a zero magnitude is treated as non-negative
   function automatic logic sm_gt(input logic [15:0] a, input logic [15:0] b);
      logic an, bn;
      an = a[SIGN_BIT] & |a[SIGN_BIT-1:0];
      bn = b[SIGN_BIT] & |b[SIGN_BIT-1:0];
      return (an != bn) ? bn : an ? (a[SIGN_BIT-1:0] < b[SIGN_BIT-1:0]) : (a[SIGN_BIT-1:0] > b[SIGN_BIT-1:0]);
   endfunction
endpackage

// File: rtl/arrhythmia_infer_ctrl_if.sv
// arrhythmia_if: sample-in, result-out and datapath signals of the inference sequencer
interface arrhythmia_if #(parameter int BITSIZE = 16, parameter int N_FEAT = 10);
   logic                      in_valid, in_ready, in_label;
   logic [BITSIZE*N_FEAT-1:0] in_x, dp_x;
   logic                      dp_reset, dp_done;
   logic [BITSIZE-1:0]        dp_y1, dp_y2, out_y1, out_y2;
   logic                      out_valid, out_ready, out_pred, out_match, out_timeout;
   modport master (
      output in_valid, in_x, in_label, out_ready, dp_done, dp_y1, dp_y2,
      input  in_ready, dp_reset, dp_x, out_valid, out_pred, out_match, out_timeout, out_y1, out_y2
   );
   modport slave (
      input  in_valid, in_x, in_label, out_ready, dp_done, dp_y1, dp_y2,
      output in_ready, dp_reset, dp_x, out_valid, out_pred, out_match, out_timeout, out_y1, out_y2
   );
endinterface

// File: rtl/arrhythmia_sm_gt.sv
// arrhythmia_sm_gt: combinational a > b for sign-magnitude words
module arrhythmia_sm_gt #(parameter int W = 16) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt
);
   logic an, bn;
   // a negative zero counts as non-negative so that +0 == -0
   assign an = a[W-1] & |a[W-2:0];
   assign bn = b[W-1] & |b[W-2:0];
   assign gt = (an != bn) ? bn : an ? (a[W-2:0] < b[W-2:0]) : (a[W-2:0] > b[W-2:0]);
endmodule

// File: rtl/arrhythmia_infer_ctrl.sv
// arrhythmia_infer_ctrl: runs one sample through the VAE/classifier datapath and keeps accuracy statistics
module arrhythmia_infer_ctrl
   import arrhythmia_pkg::*;
#(
   parameter int BITSIZE    = 16,
   parameter int N_FEAT     = 10,
   parameter int CLR_CYCLES = 2,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   arrhythmia_if.slave      bus,
   input  logic             stat_clear,
   output logic [CNT_W-1:0] stat_total,
   output logic [CNT_W-1:0] stat_correct,
   output logic [CNT_W-1:0] stat_timeout,
   output logic             busy
);
   localparam int CW = $clog2(CLR_CYCLES + 1);
   localparam int RW = $clog2(TIMEOUT + 1);
   state_t                    state;
   logic [BITSIZE*N_FEAT-1:0] x_q;
   logic                      label_q, gt;
   logic [CW-1:0]             clr_cnt;
   logic [RW-1:0]             run_cnt;
   arrhythmia_sm_gt #(.W(BITSIZE)) u_gt (.a(bus.dp_y1), .b(bus.dp_y2), .gt(gt));
   assign bus.dp_x = x_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         bus.in_ready    <= 1'b1;
         bus.dp_reset    <= 1'b1;
         bus.out_valid   <= 1'b0;
         bus.out_pred    <= 1'b0;
         bus.out_match   <= 1'b0;
         bus.out_timeout <= 1'b0;
         bus.out_y1      <= '0;
         bus.out_y2      <= '0;
         busy            <= 1'b0;
         x_q             <= '0;
         label_q         <= 1'b0;
         clr_cnt         <= '0;
         run_cnt         <= '0;
         stat_total      <= '0;
         stat_correct    <= '0;
         stat_timeout    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid && bus.in_ready) begin
               x_q          <= bus.in_x;
               label_q      <= bus.in_label;
               clr_cnt      <= '0;
               bus.in_ready <= 1'b0;
               busy         <= 1'b1;
               state        <= CLEAR;
            end
            // dp_done may still be high from the previous sample here, so it is not looked at
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
                  bus.dp_reset <= 1'b0;
                  run_cnt      <= '0;
                  state        <= RUN;
               end
            end
            RUN: if (bus.dp_done || run_cnt == RW'(TIMEOUT - 1)) begin
               bus.out_y1      <= bus.dp_done ? bus.dp_y1 : '0;
               bus.out_y2      <= bus.dp_done ? bus.dp_y2 : '0;
               bus.out_pred    <= bus.dp_done && gt;
               bus.out_match   <= bus.dp_done && (gt == label_q);
               bus.out_timeout <= !bus.dp_done;
               bus.out_valid   <= 1'b1;
               state           <= RESULT;
            end else begin
               run_cnt <= run_cnt + 1'b1;
            end
            RESULT: if (bus.out_ready) begin
               stat_total    <= stat_total + CNT_W'(!(&stat_total));
               stat_correct  <= stat_correct + CNT_W'(bus.out_match && !(&stat_correct));
               stat_timeout  <= stat_timeout + CNT_W'(bus.out_timeout && !(&stat_timeout));
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               bus.dp_reset  <= 1'b1;
               busy          <= 1'b0;
               state         <= IDLE;
            end
         endcase
         // a clear overrides any increment taken on the same edge
         if (stat_clear) begin
            stat_total   <= '0;
            stat_correct <= '0;
            stat_timeout <= '0;
         end
      end
   end
endmodule

// File: tb/tb_arrhythmia_infer_ctrl.sv
// tb_arrhythmia_infer_ctrl: randomized self-checking bench with a value-level reference model
module tb_arrhythmia_infer_ctrl;
   localparam int CLR = 2;
   localparam int TO  = 8;
   logic       clk = 0, reset = 0, stat_clear = 0, busy;
   logic [1:0] stat_total, stat_correct, stat_timeout;
   int         n_checks = 0, n_pass = 0;
   arrhythmia_if #(.BITSIZE(16), .N_FEAT(10)) bus ();
   arrhythmia_infer_ctrl #(.BITSIZE(16), .N_FEAT(10), .CLR_CYCLES(CLR), .TIMEOUT(TO), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .bus(bus), .stat_clear(stat_clear),
      .stat_total(stat_total), .stat_correct(stat_correct), .stat_timeout(stat_timeout), .busy(busy)
   );
   always #5 clk = ~clk;
   int          obs_lat, obs_clr;
   logic        obs_acc, obs_x_ok, obs_stable, obs_pred, obs_match, obs_to, obs_after_valid, obs_after_ready;
   logic [15:0] obs_y1, obs_y2;
   int          exp_lat;
   logic        exp_pred, exp_match, exp_to;
   logic [15:0] exp_y1, exp_y2;
   logic [1:0]  exp_total = 0, exp_correct = 0, exp_timeout = 0;
   function automatic bit ref_gt(input logic [15:0] a, input logic [15:0] b);
      int va, vb;
      va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
      vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
      return va > vb;
   endfunction
   function automatic logic [1:0] sat_inc(input logic [1:0] v, input bit inc);
      return (inc && v != 2'd3) ? v + 2'd1 : v;
   endfunction
   // k = RUN cycle on which dp_done is raised, -1 for never
   task automatic do_sample(input logic [159:0] x, input logic lbl, input int k, input logic [15:0] y1,
                            input logic [15:0] y2, input int hold, input bit early, input bit clr);
      logic [15:0] s_y1, s_y2;
      logic        s_p, s_m, s_t;
      logic [1:0]  s_tot, s_cor, s_tmo;
      exp_to    = (k < 0);
      exp_lat   = exp_to ? TO + CLR + 1 : k + CLR + 2;
      exp_pred  = !exp_to && ref_gt(y1, y2);
      exp_match = !exp_to && (exp_pred == lbl);
      exp_y1    = exp_to ? 16'h0 : y1;
      exp_y2    = exp_to ? 16'h0 : y2;
      @(negedge clk);
      obs_acc = bus.in_ready;
      bus.in_valid = 1; bus.in_x = x; bus.in_label = lbl;
      @(negedge clk);
      bus.in_valid = 0;
      obs_lat = 0; obs_clr = 0; obs_x_ok = 1; obs_stable = 1;
      for (int e = 1; e <= 40; e++) begin
         if (bus.out_valid) begin obs_lat = e; break; end
         if (bus.dp_reset) obs_clr++;
         if (bus.dp_x !== x) obs_x_ok = 0;
         bus.dp_done = (k >= 0 && e == k + CLR + 1) || (early && e <= CLR);
         bus.dp_y1   = (early && e <= CLR) ? ~y1 : y1;
         bus.dp_y2   = (early && e <= CLR) ? ~y2 : y2;
         @(negedge clk);
      end
      bus.dp_done = 0;
      if (obs_lat == 0) return;
      obs_pred = bus.out_pred; obs_match = bus.out_match; obs_to = bus.out_timeout;
      obs_y1 = bus.out_y1; obs_y2 = bus.out_y2;
      s_p = obs_pred; s_m = obs_match; s_t = obs_to; s_y1 = obs_y1; s_y2 = obs_y2;
      s_tot = stat_total; s_cor = stat_correct; s_tmo = stat_timeout;
      repeat (hold) begin
         bus.in_valid = 1; bus.in_x = {$urandom, $urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (bus.out_valid !== 1 || bus.in_ready !== 0 || bus.out_pred !== s_p || bus.out_match !== s_m ||
             bus.out_timeout !== s_t || bus.out_y1 !== s_y1 || bus.out_y2 !== s_y2 ||
             stat_total !== s_tot || stat_correct !== s_cor || stat_timeout !== s_tmo) obs_stable = 0;
      end
      bus.in_valid = 0; bus.out_ready = 1; stat_clear = clr;
      @(negedge clk);
      bus.out_ready = 0; stat_clear = 0;
      obs_after_valid = bus.out_valid; obs_after_ready = bus.in_ready;
      exp_total   = clr ? 2'd0 : sat_inc(exp_total, 1);
      exp_correct = clr ? 2'd0 : sat_inc(exp_correct, exp_match);
      exp_timeout = clr ? 2'd0 : sat_inc(exp_timeout, exp_to);
   endtask
   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks += 8;
      if (bus.in_ready !== 1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
      if (bus.dp_reset !== 1) $display("FAIL reset_dp_reset: got %b want 1", bus.dp_reset); else n_pass++;
      if (bus.out_valid !== 0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
      if (busy !== 0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      if (bus.dp_x !== 160'h0) $display("FAIL reset_dp_x: got %h want 0", bus.dp_x); else n_pass++;
      if (bus.out_y1 !== 16'h0 || bus.out_y2 !== 16'h0) $display("FAIL reset_out_y: got %h/%h want 0/0", bus.out_y1, bus.out_y2); else n_pass++;
      if (bus.out_timeout !== 0 || bus.out_pred !== 0) $display("FAIL reset_out_flags: got %b%b want 00", bus.out_timeout, bus.out_pred); else n_pass++;
      if ({stat_total, stat_correct, stat_timeout} !== 6'h0) $display("FAIL reset_stats: got %h want 0", {stat_total, stat_correct, stat_timeout}); else n_pass++;
      reset = 1;
   endtask
   task automatic test_basic;
      logic [159:0] x = {$urandom, $urandom, $urandom, $urandom, $urandom};
      do_sample(x, 1, 3, 16'h0800, 16'h0400, 0, 0, 0);
      n_checks += 10;
      if (obs_acc !== 1) $display("FAIL basic_accept: got %b want 1", obs_acc); else n_pass++;
      if (obs_clr !== CLR) $display("FAIL basic_dp_reset_cycles: got %0d want %0d", obs_clr, CLR); else n_pass++;
      if (obs_x_ok !== 1) $display("FAIL basic_dp_x_stable: got %b want 1", obs_x_ok); else n_pass++;
      if (obs_lat !== 7) $display("FAIL basic_latency: got %0d want 7", obs_lat); else n_pass++;
      if (obs_pred !== 1 || obs_match !== 1 || obs_to !== 0) $display("FAIL basic_result: got p%b m%b t%b want p1 m1 t0", obs_pred, obs_match, obs_to); else n_pass++;
      if (obs_y1 !== 16'h0800 || obs_y2 !== 16'h0400) $display("FAIL basic_y: got %h/%h want 0800/0400", obs_y1, obs_y2); else n_pass++;
      if (obs_after_valid !== 0) $display("FAIL basic_valid_drop: got %b want 0", obs_after_valid); else n_pass++;
      if (obs_after_ready !== 1) $display("FAIL basic_ready_back: got %b want 1", obs_after_ready); else n_pass++;
      if (stat_total !== 2'd1 || stat_correct !== 2'd1) $display("FAIL basic_stats: got total %0d correct %0d want 1 1", stat_total, stat_correct); else n_pass++;
      if (stat_timeout !== 2'd0) $display("FAIL basic_stat_timeout: got %0d want 0", stat_timeout); else n_pass++;
   endtask
   task automatic test_compare;
      logic [15:0] ya [3] = '{16'h8800, 16'h8000, 16'h8400};
      logic [15:0] yb [3] = '{16'h0400, 16'h0000, 16'h8800};
      logic        wp [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         do_sample({5{$urandom}}, 1, 0, ya[i], yb[i], 0, 0, 1);
         n_checks += 2;
         if (obs_pred !== wp[i]) $display("FAIL cmp_pred_%0d: got %b want %b", i, obs_pred, wp[i]); else n_pass++;
         if (obs_match !== wp[i]) $display("FAIL cmp_match_%0d: got %b want %b", i, obs_match, wp[i]); else n_pass++;
      end
   endtask
   task automatic test_timeout;
      do_sample({5{$urandom}}, 0, -1, 16'h1234, 16'h0042, 0, 0, 0);
      n_checks += 4;
      if (obs_lat !== TO + CLR + 1) $display("FAIL to_latency: got %0d want %0d", obs_lat, TO + CLR + 1); else n_pass++;
      if (obs_to !== 1 || obs_pred !== 0 || obs_match !== 0) $display("FAIL to_flags: got t%b p%b m%b want t1 p0 m0", obs_to, obs_pred, obs_match); else n_pass++;
      if (obs_y1 !== 16'h0 || obs_y2 !== 16'h0) $display("FAIL to_y: got %h/%h want 0/0", obs_y1, obs_y2); else n_pass++;
      if (stat_total !== 2'd1 || stat_correct !== 2'd0 || stat_timeout !== 2'd1) $display("FAIL to_stats: got %0d/%0d/%0d want 1/0/1", stat_total, stat_correct, stat_timeout); else n_pass++;
      do_sample({5{$urandom}}, 1, TO - 1, 16'h0C00, 16'h8100, 0, 0, 0);
      n_checks += 3;
      if (obs_lat !== TO + CLR + 1) $display("FAIL last_latency: got %0d want %0d", obs_lat, TO + CLR + 1); else n_pass++;
      if (obs_to !== 0 || obs_y1 !== 16'h0C00 || obs_y2 !== 16'h8100) $display("FAIL last_capture: got t%b %h/%h want t0 0c00/8100", obs_to, obs_y1, obs_y2); else n_pass++;
      if (stat_total !== 2'd2 || stat_correct !== 2'd1 || stat_timeout !== 2'd1) $display("FAIL last_stats: got %0d/%0d/%0d want 2/1/1", stat_total, stat_correct, stat_timeout); else n_pass++;
   endtask
   task automatic test_backpressure;
      do_sample({5{$urandom}}, 0, 2, 16'h0100, 16'h0200, 5, 1, 0);
      n_checks += 4;
      if (obs_lat !== exp_lat) $display("FAIL bp_latency: got %0d want %0d", obs_lat, exp_lat); else n_pass++;
      if (obs_stable !== 1) $display("FAIL bp_stable: got %b want 1", obs_stable); else n_pass++;
      if (obs_y1 !== 16'h0100 || obs_match !== 1) $display("FAIL bp_result: got %h m%b want 0100 m1", obs_y1, obs_match); else n_pass++;
      if (stat_total !== exp_total || stat_correct !== exp_correct) $display("FAIL bp_stats: got %0d/%0d want %0d/%0d", stat_total, stat_correct, exp_total, exp_correct); else n_pass++;
   endtask
   task automatic test_reset_mid;
      @(negedge clk);
      bus.in_valid = 1; bus.in_x = {5{$urandom}}; bus.in_label = 1;
      @(negedge clk);
      bus.in_valid = 0;
      repeat (4) @(negedge clk);
      #2 reset = 0;
      #1;
      n_checks += 3;
      if (bus.dp_reset !== 1 || bus.in_ready !== 1) $display("FAIL mid_reset_ctrl: got dp_reset %b in_ready %b want 1 1", bus.dp_reset, bus.in_ready); else n_pass++;
      if (bus.out_valid !== 0 || busy !== 0) $display("FAIL mid_reset_idle: got out_valid %b busy %b want 0 0", bus.out_valid, busy); else n_pass++;
      if ({stat_total, stat_correct, stat_timeout} !== 6'h0) $display("FAIL mid_reset_stats: got %h want 0", {stat_total, stat_correct, stat_timeout}); else n_pass++;
      exp_total = 0; exp_correct = 0; exp_timeout = 0;
      @(negedge clk);
      reset = 1;
      do_sample({5{$urandom}}, 0, 1, 16'h0300, 16'h0500, 0, 0, 0);
      n_checks += 2;
      if (obs_lat !== 5 || obs_match !== 1) $display("FAIL mid_next: got lat %0d m%b want 5 m1", obs_lat, obs_match); else n_pass++;
      if (stat_total !== 2'd1 || stat_correct !== 2'd1) $display("FAIL mid_next_stats: got %0d/%0d want 1/1", stat_total, stat_correct); else n_pass++;
   endtask
   task automatic test_stats;
      do_sample({5{$urandom}}, 1, 0, 16'h0800, 16'h0400, 1, 0, 1);
      n_checks += 1;
      if ({stat_total, stat_correct, stat_timeout} !== 6'h0) $display("FAIL clear_on_hs: got %h want 0", {stat_total, stat_correct, stat_timeout}); else n_pass++;
      repeat (5) do_sample({5{$urandom}}, 1, 0, 16'h0800, 16'h0400, 0, 0, 0);
      n_checks += 2;
      if (stat_correct !== 2'd3) $display("FAIL sat_correct: got %0d want 3", stat_correct); else n_pass++;
      if (stat_total !== 2'd3 || stat_timeout !== 2'd0) $display("FAIL sat_total: got %0d/%0d want 3/0", stat_total, stat_timeout); else n_pass++;
   endtask
   task automatic test_random;
      logic [15:0] y1, y2;
      int          k;
      for (int i = 0; i < 12; i++) begin
         y1 = 16'($urandom);
         y2 = ($urandom_range(0, 3) == 0) ? y1 : 16'($urandom);
         if ($urandom_range(0, 5) == 0) begin y1 = 16'h8000; y2 = 16'h0000; end
         k = $urandom_range(0, 9);
         do_sample({5{$urandom}}, 1'($urandom), (k >= TO) ? -1 : k, y1, y2, $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 7) == 0);
         n_checks += 6;
         if (obs_lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, obs_lat, exp_lat); else n_pass++;
         if (obs_pred !== exp_pred || obs_match !== exp_match) $display("FAIL rnd%0d_pred: got p%b m%b want p%b m%b", i, obs_pred, obs_match, exp_pred, exp_match); else n_pass++;
         if (obs_to !== exp_to) $display("FAIL rnd%0d_timeout: got %b want %b", i, obs_to, exp_to); else n_pass++;
         if (obs_y1 !== exp_y1 || obs_y2 !== exp_y2) $display("FAIL rnd%0d_y: got %h/%h want %h/%h", i, obs_y1, obs_y2, exp_y1, exp_y2); else n_pass++;
         if (obs_stable !== 1 || obs_clr !== CLR) $display("FAIL rnd%0d_hold: got stable %b clr %0d want 1 %0d", i, obs_stable, obs_clr, CLR); else n_pass++;
         if (stat_total !== exp_total || stat_correct !== exp_correct || stat_timeout !== exp_timeout)
            $display("FAIL rnd%0d_stats: got %0d/%0d/%0d want %0d/%0d/%0d", i, stat_total, stat_correct, stat_timeout, exp_total, exp_correct, exp_timeout);
         else n_pass++;
      end
   endtask
   initial begin
      bus.in_valid = 0; bus.in_x = '0; bus.in_label = 0; bus.out_ready = 0;
      bus.dp_done = 0; bus.dp_y1 = '0; bus.dp_y2 = '0;
      test_reset;
      test_basic;
      test_compare;
      test_timeout;
      test_backpressure;
      test_reset_mid;
      test_stats;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
